emulib_rammodel_timing_sched: RTL and testbench
===============================================

Name: emulib_rammodel_timing_sched

Overview:
- Fixed-latency timing scheduler for the RAM model frontend, in the target clock domain.
- Admits AR and AW requests up to a bounded in-flight count.
- Pairs AW with W-last completions.
- Releases read and write-response requests to the backend (rreq/breq) no earlier than R_DELAY / W_DELAY target cycles after acceptance, in acceptance order per channel.

Parameters:
- ID_WIDTH, 4: AXI ID width.
- MAX_INFLIGHT, 8: per-channel in-flight limit. Power of 2, at least 2.
- R_DELAY, 25: AR accept to earliest rreq_valid, in cycles. At least 1.
- W_DELAY, 3: AW+W-last pairing to earliest breq_valid, in cycles. At least 1.

Ports:
- clk, in, 1: target clock.
- rst_n, in, 1: asynchronous active-low reset.
- ar_fire, in, 1: AR handshake this cycle.
- ar_id, in, ID_WIDTH: ID of the AR.
- ar_allow, out, 1: frontend ANDs this into arready.
- aw_fire, in, 1: AW handshake this cycle.
- aw_id, in, ID_WIDTH: ID of the AW.
- aw_allow, out, 1: frontend ANDs this into awready.
- wlast_fire, in, 1: W handshake with wlast=1 this cycle.
- rreq_valid, out, 1: read request release.
- rreq_id, out, ID_WIDTH: ID of the released read.
- rreq_ready, in, 1: backend accepts the read release.
- breq_valid, out, 1: write-response request release.
- breq_id, out, ID_WIDTH: ID of the released write response.
- breq_ready, in, 1: backend accepts the write-response release.
- r_inflight, out, clog2(MAX_INFLIGHT)+1: RQ occupancy.
- w_inflight, out, clog2(MAX_INFLIGHT)+1: AWQ plus BQ occupancy.
- err_wlast, out, 1: sticky; W-last counter overflow.

Behaviour:
- Reset (async assert, sync deassert external):
  - all queues empty, counters 0;
  - rreq_valid=0, breq_valid=0, err_wlast=0;
  - ar_allow=1, aw_allow=1;
  - r_inflight=0, w_inflight=0.
- Three circular FIFOs, depth MAX_INFLIGHT, each with wr/rd pointers one bit wider than the index (full = MSBs differ, lower bits equal):
  - RQ: {id, cnt}
  - AWQ: {id}
  - BQ: {id, cnt}
- cnt width is clog2(max(R_DELAY,W_DELAY)).
- Admission:
  - ar_allow = (RQ count < MAX_INFLIGHT).
  - aw_allow = (AWQ count + BQ count < MAX_INFLIGHT).
  - Both come from registered state only. A pop in the same cycle does not free a slot until the next cycle.
  - A fire while allow=0 is a protocol violation. It is ignored (no push).
- Read path:
  - ar_fire at cycle t pushes {ar_id, R_DELAY-1} into RQ.
  - Every cycle, each valid RQ entry with cnt != 0 decrements by 1 (saturating at 0).
  - rreq_valid = RQ non-empty and head cnt == 0. The earliest assertion is cycle t+R_DELAY.
  - rreq_id = head id.
  - Pop on rreq_valid & rreq_ready.
  - While rreq_ready is low, valid and id are held stable. Later entries keep counting down, so they release back-to-back, one per cycle, once the head pops.
- Write pairing:
  - aw_fire pushes aw_id into AWQ.
  - wlast_fire increments wl_cnt (width clog2(MAX_INFLIGHT)+1). W may precede AW.
  - Pair when AWQ non-empty and (wl_cnt != 0 or wlast_fire): pop AWQ, decrement the effective wl_cnt, push {id, W_DELAY-1} into BQ. At most one pair per cycle.
  - The cycle after the pair is cycle 1 of the W_DELAY count.
  - Same-cycle aw_fire into an empty AWQ pairs on the next cycle; there is no bypass.
  - wlast_fire while wl_cnt == MAX_INFLIGHT sets err_wlast. The count saturates and is not incremented.
- Write release:
  - BQ countdown, breq_valid, breq_id and the breq_ready pop are identical to the read path.
- Simultaneous push and pop on any FIFO in one cycle is legal. Occupancy is unchanged.
- Counters never wrap. Only pointers wrap, modulo 2*MAX_INFLIGHT.
- Reset mid-operation: all in-flight entries are discarded. No release is emitted after reset deasserts.

Decomposition:
- Package emulib_rammodel_pkg holds:
  - typedef sched_entry_t {id, cnt};
  - function clog2;
  - constant CNT_W derived from max(R_DELAY, W_DELAY).
- One sub-module, emulib_rammodel_delay_fifo, parameters DEPTH and DELAY:
  - push/id in;
  - per-entry countdown;
  - head valid when cnt==0;
  - ready pop;
  - count out.
- Instantiate it twice, for RQ and BQ. AWQ and the pairing logic stay in the top.

Test Plan:
- Single read, R_DELAY=25: ar_fire id=3 at cycle 10 with rreq_ready=1 → rreq_valid=1, rreq_id=3 exactly at cycle 35 for one cycle; r_inflight returns to 0 at cycle 36.
- Full, MAX_INFLIGHT=8: 8 ARs on consecutive cycles → ar_allow=0 from the cycle after the 8th. The first pop re-asserts ar_allow one cycle later. rreq IDs come out in issue order 0..7.
- Backpressure: hold rreq_ready=0 for 40 cycles after 4 reads issued back-to-back → head held stable; after release, 4 rreq_valid on 4 consecutive cycles.
- W before AW, W_DELAY=3: wlast_fire at cycle 5, aw_fire id=9 at cycle 8 → pair at cycle 9, breq_valid id=9 at cycle 12.
- Overflow: 9 wlast_fire pulses with no AW → err_wlast=1 after the 9th; wl_cnt stays 8.
- Async reset: assert rst_n=0 mid-countdown with 3 reads pending → outputs at reset values immediately, without a clock edge; no rreq_valid after deassertion.

Source files
------------

// File: rtl/emulib_rammodel_pkg.sv
// emulib_rammodel_pkg: shared sizing helpers and the delayed-release entry layout.
package emulib_rammodel_pkg;
  function automatic int clog2(input int v);
    int r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
  function automatic int cnt_w(input int r, input int w);
    int m = r > w ? r : w;
    return clog2(m) < 1 ? 1 : clog2(m);
  endfunction
  localparam int ID_WIDTH_DEF = 4;
  localparam int R_DELAY_DEF = 25;
  localparam int W_DELAY_DEF = 3;
  localparam int CNT_W = cnt_w(R_DELAY_DEF, W_DELAY_DEF);
  typedef struct packed {
    logic [ID_WIDTH_DEF-1:0] id;
    logic [CNT_W-1:0] cnt;
  } sched_entry_t;
endpackage

// File: rtl/emulib_rammodel_delay_fifo.sv
// emulib_rammodel_delay_fifo: circular FIFO whose entries count down and release in order at zero.
module emulib_rammodel_delay_fifo
  import emulib_rammodel_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DELAY = 25,
  parameter int ID_W = 4,
  parameter int CNT_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [ID_W-1:0]       push_id,
  input  logic                  ready,
  output logic                  valid,
  output logic [ID_W-1:0]       head_id,
  output logic [clog2(DEPTH):0] count
);
  localparam int AW = clog2(DEPTH);
  logic [AW:0] wr, rd;
  logic [ID_W-1:0] ids [DEPTH];
  logic [CNT_W-1:0] cnts [DEPTH];
  logic full, do_push, do_pop;
  assign full = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
  assign count = wr - rd;
  assign head_id = ids[rd[AW-1:0]];
  assign valid = (wr != rd) && (cnts[rd[AW-1:0]] == '0);
  assign do_push = push && !full;
  assign do_pop = valid && ready;
  // Stale slots also count down; harmless since a push overwrites the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr <= '0;
      rd <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ids[i] <= '0;
        cnts[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) if (cnts[i] != '0) cnts[i] <= cnts[i] - 1'b1;
      if (do_push) begin
        ids[wr[AW-1:0]] <= push_id;
        cnts[wr[AW-1:0]] <= CNT_W'(DELAY - 1);
        wr <= wr + 1'b1;
      end
      if (do_pop) rd <= rd + 1'b1;
    end
  end
endmodule

// File: rtl/emulib_rammodel_timing_sched.sv
// emulib_rammodel_timing_sched: admits AR/AW, pairs AW with W-last, releases rreq/breq after fixed delays.
module emulib_rammodel_timing_sched
  import emulib_rammodel_pkg::*;
#(
  parameter int ID_WIDTH = 4,
  parameter int MAX_INFLIGHT = 8,
  parameter int R_DELAY = 25,
  parameter int W_DELAY = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ar_fire,
  input  logic [ID_WIDTH-1:0]          ar_id,
  output logic                         ar_allow,
  input  logic                         aw_fire,
  input  logic [ID_WIDTH-1:0]          aw_id,
  output logic                         aw_allow,
  input  logic                         wlast_fire,
  output logic                         rreq_valid,
  output logic [ID_WIDTH-1:0]          rreq_id,
  input  logic                         rreq_ready,
  output logic                         breq_valid,
  output logic [ID_WIDTH-1:0]          breq_id,
  input  logic                         breq_ready,
  output logic [clog2(MAX_INFLIGHT):0] r_inflight,
  output logic [clog2(MAX_INFLIGHT):0] w_inflight,
  output logic                         err_wlast
);
  localparam int AW = clog2(MAX_INFLIGHT);
  localparam int CW = cnt_w(R_DELAY, W_DELAY);
  localparam logic [AW:0] MAXV = (AW + 1)'(MAX_INFLIGHT);
  logic [AW:0] aw_wr, aw_rd, awq_count, b_count, wl_cnt;
  logic [ID_WIDTH-1:0] aw_ids [MAX_INFLIGHT];
  logic pair, wl_sat;
  assign awq_count = aw_wr - aw_rd;
  assign w_inflight = awq_count + b_count;
  assign ar_allow = r_inflight < MAXV;
  assign aw_allow = w_inflight < MAXV;
  assign wl_sat = wl_cnt == MAXV;
  // No bypass: an AW is only pairable once it sits in the AWQ.
  assign pair = (aw_wr != aw_rd) && (wl_cnt != '0 || wlast_fire);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_wr <= '0;
      aw_rd <= '0;
      wl_cnt <= '0;
      err_wlast <= 1'b0;
      for (int i = 0; i < MAX_INFLIGHT; i++) aw_ids[i] <= '0;
    end else begin
      if (aw_fire && aw_allow) begin
        aw_ids[aw_wr[AW-1:0]] <= aw_id;
        aw_wr <= aw_wr + 1'b1;
      end
      if (pair) aw_rd <= aw_rd + 1'b1;
      wl_cnt <= wl_cnt + (AW + 1)'(wlast_fire && !wl_sat) - (AW + 1)'(pair);
      if (wlast_fire && wl_sat) err_wlast <= 1'b1;
    end
  end
  emulib_rammodel_delay_fifo #(
    .DEPTH(MAX_INFLIGHT), .DELAY(R_DELAY), .ID_W(ID_WIDTH), .CNT_W(CW)
  ) u_rq (
    .clk(clk), .rst_n(rst_n), .push(ar_fire && ar_allow), .push_id(ar_id),
    .ready(rreq_ready), .valid(rreq_valid), .head_id(rreq_id), .count(r_inflight)
  );
  emulib_rammodel_delay_fifo #(
    .DEPTH(MAX_INFLIGHT), .DELAY(W_DELAY), .ID_W(ID_WIDTH), .CNT_W(CW)
  ) u_bq (
    .clk(clk), .rst_n(rst_n), .push(pair), .push_id(aw_ids[aw_rd[AW-1:0]]),
    .ready(breq_ready), .valid(breq_valid), .head_id(breq_id), .count(b_count)
  );
endmodule

// File: tb/tb_emulib_rammodel_timing_sched.sv
// tb_emulib_rammodel_timing_sched: directed vectors for the RAM model timing scheduler.
module tb_emulib_rammodel_timing_sched;
  logic clk = 0, rst_n = 0;
  logic ar_fire = 0, aw_fire = 0, wlast_fire = 0, rreq_ready = 0, breq_ready = 0;
  logic [3:0] ar_id = 0, aw_id = 0;
  logic ar_allow, aw_allow, rreq_valid, breq_valid, err_wlast;
  logic [3:0] rreq_id, breq_id;
  logic [3:0] r_inflight, w_inflight;
  int vec = 0, miss = 0;

  emulib_rammodel_timing_sched dut (
    .clk(clk), .rst_n(rst_n), .ar_fire(ar_fire), .ar_id(ar_id), .ar_allow(ar_allow),
    .aw_fire(aw_fire), .aw_id(aw_id), .aw_allow(aw_allow), .wlast_fire(wlast_fire),
    .rreq_valid(rreq_valid), .rreq_id(rreq_id), .rreq_ready(rreq_ready),
    .breq_valid(breq_valid), .breq_id(breq_id), .breq_ready(breq_ready),
    .r_inflight(r_inflight), .w_inflight(w_inflight), .err_wlast(err_wlast)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    vec++;
    if (got !== exp) begin
      miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, bad, cnt;
    tick;
    tick;
    chk("rst_ar_allow", ar_allow, 1);
    chk("rst_aw_allow", aw_allow, 1);
    chk("rst_rreq_valid", rreq_valid, 0);
    chk("rst_breq_valid", breq_valid, 0);
    chk("rst_r_inflight", r_inflight, 0);
    chk("rst_w_inflight", w_inflight, 0);
    chk("rst_err_wlast", err_wlast, 0);
    rst_n = 1;
    repeat (3) tick;
    // single read: latency from the AR cycle to rreq_valid is R_DELAY
    rreq_ready = 1;
    ar_fire = 1; ar_id = 3;
    tick;
    ar_fire = 0;
    chk("rd1_inflight", r_inflight, 1);
    chk("rd1_early", rreq_valid, 0);
    n = 1;
    while (!rreq_valid && n < 100) begin tick; n++; end
    chk("rd1_latency", n, 25);
    chk("rd1_id", rreq_id, 3);
    tick;
    chk("rd1_one_cycle", rreq_valid, 0);
    chk("rd1_drain", r_inflight, 0);
    // fill to MAX_INFLIGHT, then an illegal ninth fire is ignored
    for (int i = 0; i < 8; i++) begin
      ar_fire = 1; ar_id = 4'(i);
      tick;
    end
    chk("full_allow", ar_allow, 0);
    chk("full_inflight", r_inflight, 8);
    ar_id = 15;
    tick;
    ar_fire = 0;
    chk("full_ignored", r_inflight, 8);
    n = 0;
    while (!rreq_valid && n < 100) begin tick; n++; end
    chk("full_seen", rreq_valid, 1);
    chk("full_allow_at_pop", ar_allow, 0);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (!rreq_valid || rreq_id != 4'(i)) bad++;
      tick;
      if (i == 0) chk("full_allow_after_pop", ar_allow, 1);
    end
    chk("full_order_errs", bad, 0);
    chk("full_drain", r_inflight, 0);
    // backpressure: head held, then back-to-back release
    rreq_ready = 0;
    for (int i = 0; i < 4; i++) begin
      ar_fire = 1; ar_id = 4'(10 + i);
      tick;
    end
    ar_fire = 0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (rreq_valid && rreq_id != 4'd10) bad++;
      tick;
    end
    chk("bp_held_valid", rreq_valid, 1);
    chk("bp_held_id", rreq_id, 10);
    chk("bp_stable_errs", bad, 0);
    rreq_ready = 1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (!rreq_valid || rreq_id != 4'(10 + i)) bad++;
      tick;
    end
    chk("bp_burst_errs", bad, 0);
    chk("bp_done", rreq_valid, 0);
    // W-last before AW: pair one cycle after AW, breq W_DELAY later
    wlast_fire = 1;
    tick;
    wlast_fire = 0;
    tick;
    tick;
    aw_fire = 1; aw_id = 9;
    chk("wa_inflight0", w_inflight, 0);
    tick;
    aw_fire = 0;
    chk("wa_inflight_awq", w_inflight, 1);
    n = 1;
    while (!breq_valid && n < 100) begin tick; n++; end
    chk("wa_latency", n, 4);
    chk("wa_id", breq_id, 9);
    breq_ready = 1;
    tick;
    chk("wa_done", breq_valid, 0);
    chk("wa_drain", w_inflight, 0);
    // W-last overflow: ninth pulse with no AW sets the sticky error
    wlast_fire = 1;
    repeat (8) tick;
    chk("ovf_pre", err_wlast, 0);
    tick;
    wlast_fire = 0;
    chk("ovf_err", err_wlast, 1);
    bad = 0; cnt = 0;
    for (int i = 0; i < 8; i++) begin
      aw_fire = 1; aw_id = 4'(i);
      if (breq_valid) begin
        if (breq_id != 4'(cnt)) bad++;
        cnt++;
      end
      tick;
    end
    aw_fire = 0;
    for (int i = 0; i < 40; i++) begin
      if (breq_valid) begin
        if (breq_id != 4'(cnt)) bad++;
        cnt++;
      end
      tick;
    end
    chk("ovf_releases", cnt, 8);
    chk("ovf_order_errs", bad, 0);
    aw_fire = 1; aw_id = 5;
    tick;
    aw_fire = 0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (breq_valid) cnt++;
      tick;
    end
    chk("ovf_no_extra", cnt, 0);
    chk("ovf_stuck_aw", w_inflight, 1);
    chk("ovf_sticky", err_wlast, 1);
    // async reset mid-countdown
    rreq_ready = 0;
    for (int i = 0; i < 3; i++) begin
      ar_fire = 1; ar_id = 4'(i + 1);
      tick;
    end
    ar_fire = 0;
    repeat (10) tick;
    chk("ar_pending", r_inflight, 3);
    rst_n = 0;
    #1;
    chk("ar_r_inflight", r_inflight, 0);
    chk("ar_w_inflight", w_inflight, 0);
    chk("ar_rreq_valid", rreq_valid, 0);
    chk("ar_err", err_wlast, 0);
    chk("ar_allow", ar_allow, 1);
    tick;
    rst_n = 1;
    rreq_ready = 1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (rreq_valid || breq_valid) cnt++;
      tick;
    end
    chk("ar_no_release", cnt, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
